// File: rtl/subtrator_serial_controle_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and the
// controller state encoding.
package subtrator_serial_controle_pkg;

   localparam int unsigned N_DEFAULT = 8;

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      CALC   = 2'd1,
      FIM    = 2'd2
   } state_t;

endpackage

// File: rtl/subtrator_completo.sv
// One-bit full subtractor cell: S = A - B - Cin, Cout = borrow out.
module subtrator_completo (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic S,
   output logic Cout
);

   assign S    = A ^ B ^ Cin;
   assign Cout = (~A & B) | (~(A ^ B) & Cin);

endmodule

// File: rtl/subtrator_serial_controle.sv
// Bit-serial N-bit subtractor: one full-subtractor cell walked over the
// operands LSB-first, one bit per clock, with a start/busy/done handshake.
module subtrator_serial_controle
   import subtrator_serial_controle_pkg::*;
#(
   parameter int unsigned N = N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] S,
   output logic         Cout
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned RW = N - 1;

   state_t          state;
   state_t          state_nxt;
   logic [N-1:0]    a_sh;
   logic [N-1:0]    b_sh;
   logic [RW-1:0]   r_sh;
   logic            borrow_reg;
   logic [CW-1:0]   cnt;
   logic            load;
   logic            step;
   logic            last;
   logic            d_bit;
   logic            b_bit;

   subtrator_completo u_cell (
      .A    (a_sh[0]),
      .B    (b_sh[0]),
      .Cin  (borrow_reg),
      .S    (d_bit),
      .Cout (b_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= OCIOSO;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and datapath controls; start is only honoured in OCIOSO/FIM
   always_comb begin
      state_nxt = OCIOSO;
      load      = 1'b0;
      step      = 1'b0;
      last      = 1'b0;
      case (state)
         OCIOSO, FIM: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            step      = 1'b1;
            last      = (cnt == CW'(N - 1));
            state_nxt = last ? FIM : CALC;
         end
         default: state_nxt = OCIOSO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh       <= '0;
         b_sh       <= '0;
         r_sh       <= '0;
         borrow_reg <= 1'b0;
         cnt        <= '0;
      end else if (load) begin
         a_sh       <= A;
         b_sh       <= B;
         r_sh       <= '0;
         borrow_reg <= Cin;
         cnt        <= '0;
      end else if (step) begin
         a_sh       <= {1'b0, a_sh[N-1:1]};
         b_sh       <= {1'b0, b_sh[N-1:1]};
         r_sh       <= RW'({d_bit, r_sh} >> 1);
         borrow_reg <= b_bit;
         cnt        <= cnt + CW'(1);
      end
   end

   // Result only moves on the edge that enters FIM; the last bit bypasses r_sh
   always_ff @(posedge clk) begin
      if (rst) begin
         S    <= '0;
         Cout <= 1'b0;
      end else if (last) begin
         S    <= {d_bit, r_sh};
         Cout <= b_bit;
      end
   end

   assign busy = (state == CALC);
   assign done = (state == FIM);

endmodule

// File: tb/tb_subtrator_serial_controle.sv
// Bench for the bit-serial subtractor: N=8 and N=4 instances checked every
// cycle against a transaction-level model, plus directed literal results.
module tb_subtrator_serial_controle;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, s8;
   logic       start4, cin4, busy4, done4, cout4;
   logic [3:0] a4, b4, s4;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic chk_en  = 1'b0;
   int   nb, got, cyc;

   always #5 clk = ~clk;

   subtrator_serial_controle #(.N(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
      .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
   );

   subtrator_serial_controle #(.N(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Cin(cin4),
      .busy(busy4), .done(done4), .S(s4), .Cout(cout4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: an accepted start schedules a result W edges later
   for (genvar g = 0; g < 2; g++) begin : mdl
      localparam int W = (g == 0) ? 8 : 4;
      logic st;
      int   av, bv, cv;
      int   left = 0;
      logic dn   = 1'b0;
      int   es   = 0;
      logic ec   = 1'b0;
      int   ps   = 0;
      logic pc   = 1'b0;

      assign st = (g == 0) ? start8 : start4;
      assign av = (g == 0) ? int'(a8) : int'(a4);
      assign bv = (g == 0) ? int'(b8) : int'(b4);
      assign cv = (g == 0) ? int'(cin8) : int'(cin4);

      always @(posedge clk) begin
         if (rst) begin
            left <= 0;
            dn   <= 1'b0;
            es   <= 0;
            ec   <= 1'b0;
         end else if (left > 0) begin
            left <= left - 1;
            dn   <= (left == 1);
            if (left == 1) begin
               es <= ps;
               ec <= pc;
            end
         end else begin
            dn <= 1'b0;
            if (st) begin
               left <= W;
               ps   <= (av - bv - cv + 2 * (1 << W)) % (1 << W);
               pc   <= (av < bv + cv);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy8", 32'(busy8), 32'(mdl[0].left > 0));
         check("done8", 32'(done8), 32'(mdl[0].dn));
         check("s8",    32'(s8),    32'(mdl[0].es));
         check("cout8", 32'(cout8), 32'(mdl[0].ec));
         check("busy4", 32'(busy4), 32'(mdl[1].left > 0));
         check("done4", 32'(done4), 32'(mdl[1].dn));
         check("s4",    32'(s4),    32'(mdl[1].es));
         check("cout4", 32'(cout4), 32'(mdl[1].ec));
      end
   end

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input string nm);
      @(posedge clk); #1;
      a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      nb = 0; got = 0;
      for (int k = 0; k < 20 && got == 0; k++) begin
         @(negedge clk);
         if (done8) got = 1;
         else if (busy8) nb++;
      end
      check({nm, "_done"}, 32'(got), 32'd1);
      check({nm, "_busy"}, 32'(nb),  32'd8);
      check({nm, "_s"},    32'(s8),  32'(es));
      check({nm, "_cout"}, 32'(cout8), 32'(ec));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_s",    32'(s8),    32'd0);
      check("rst_cout", 32'(cout8), 32'd0);

      run8(8'd5,  8'd3,  1'b0, 8'h02, 1'b0, "t1");
      run8(8'd3,  8'd5,  1'b0, 8'hFE, 1'b1, "t2a");
      run8(8'd0,  8'd0,  1'b1, 8'hFF, 1'b1, "t2b");
      run8(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, "max");
      run8(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, "wrap");

      // start held and operands scrambled while busy
      @(posedge clk); #1;
      a8 = 8'h10; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      nb = 0; got = 0;
      for (int k = 0; k < 20 && got == 0; k++) begin
         @(negedge clk);
         if (done8) begin
            got = 1;
            start8 = 1'b0;
         end else begin
            if (busy8) nb++;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         end
      end
      check("t3_done", 32'(got), 32'd1);
      check("t3_busy", 32'(nb),  32'd8);
      check("t3_s",    32'(s8),  32'h0F);
      check("t3_cout", 32'(cout8), 32'd0);

      // reset during the 4th CALC cycle aborts the operation
      @(posedge clk); #1;
      a8 = 8'h40; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("t4_busy", 32'(busy8), 32'd0);
      check("t4_done", 32'(done8), 32'd0);
      check("t4_s",    32'(s8),    32'd0);
      check("t4_cout", 32'(cout8), 32'd0);
      got = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) got++;
      end
      check("t4_nodone", 32'(got), 32'd0);

      // back-to-back start issued in the FIM cycle
      run8(8'h20, 8'h30, 1'b1, 8'hEF, 1'b1, "t5a");
      a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      @(negedge clk);
      check("t5_busy", 32'(busy8), 32'd1);
      cyc = 1;
      while (!done8 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("t5_cyc",  32'(cyc),   32'd9);
      check("t5_s",    32'(s8),    32'h7F);
      check("t5_cout", 32'(cout8), 32'd0);

      // N=4 exhaustive
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               @(posedge clk); #1;
               a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c); start4 = 1'b1;
               @(posedge clk); #1;
               start4 = 1'b0;
               got = 0;
               for (int k = 0; k < 12 && got == 0; k++) begin
                  @(negedge clk);
                  if (done4) got = 1;
               end
               check("t6_done", 32'(got),   32'd1);
               check("t6_s",    32'(s4),    32'((a - b - c) & 15));
               check("t6_cout", 32'(cout4), 32'(a < b + c));
            end
         end
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
